// File: rtl/frame_buf_manager_if.sv
// frame_buf_manager_if: frame handshake bundle between the frame-buffer manager and the
// DDR writer/reader paths.
//   wr_frame_done  writer end-of-frame level (camera domain)
//   rd_vsync       1-cycle reader frame-boundary pulse (clk_100Mhz domain)
//   wr_base_addr   DDR base address the writer must target
//   rd_base_addr   DDR base address the reader must fetch from
//   rd_frame_valid reader holds a written frame
// master = the manager (hands out addresses); slave = the writer/reader side.
interface frame_buf_manager_if;
   logic        wr_frame_done;
   logic        rd_vsync;
   logic [31:0] wr_base_addr;
   logic [31:0] rd_base_addr;
   logic        rd_frame_valid;

   modport master (
      input  wr_frame_done,
      input  rd_vsync,
      output wr_base_addr,
      output rd_base_addr,
      output rd_frame_valid
   );

   modport slave (
      output wr_frame_done,
      output rd_vsync,
      input  wr_base_addr,
      input  rd_base_addr,
      input  rd_frame_valid
   );
endinterface

// File: rtl/frame_buf_manager.sv
// frame_buf_manager: N-buffer (3..8) frame-buffer ownership tracker for camera->DDR->HDMI.
// Each buffer is FREE, WRITING, READY or READING. The writer never targets the reader's buffer.
// mode 0 = LATEST (reader takes the newest frame, stale READY frames are dropped on commit),
// mode 1 = QUEUE (reader takes the oldest frame, a commit with no FREE buffer is dropped).
// Ports:
//   clk_100Mhz, rst (async, active-high)
//   bus            frame_buf_manager_if.master (wr_frame_done, rd_vsync, addresses, rd_frame_valid)
//   mode           LATEST/QUEUE select, taken only while no buffer is READY
//   freeze         reader ignores rd_vsync
//   ready_count    buffers currently READY
//   overflow       sticky QUEUE-mode drop flag
//   frames_*       saturating statistics counters
// All outputs are registered.
module frame_buf_manager #(
   parameter int unsigned NUM_BUFS   = 3,
   parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
   parameter logic [31:0] BUF_STRIDE = 32'h0010_0000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   clk_100Mhz,
   input  logic                   rst,
   frame_buf_manager_if.master    bus,
   input  logic                   mode,
   input  logic                   freeze,
   output logic [3:0]             ready_count,
   output logic                   overflow,
   output logic [CNT_W-1:0]       frames_written,
   output logic [CNT_W-1:0]       frames_dropped,
   output logic [CNT_W-1:0]       frames_repeat
);

   localparam int unsigned IDX_W = $clog2(NUM_BUFS);
   // READY ages never exceed NUM_BUFS-3 (<= 5), so 3 bits never wrap.
   localparam int unsigned AGE_W = 3;

   typedef enum logic [1:0] {BufFree, BufWriting, BufReady, BufReading} buf_state_e;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [AGE_W-1:0] age_t;

   buf_state_e       st_q  [NUM_BUFS];
   buf_state_e       st_d  [NUM_BUFS];
   // Age tag: 0 = most recently committed READY frame, larger = older.
   age_t             age_q [NUM_BUFS];
   age_t             age_d [NUM_BUFS];
   idx_t             wr_idx_q, wr_idx_d;
   idx_t             rd_idx_q, rd_idx_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             mode_q;
   logic [3:0]       rc_q, rc_d;
   logic [31:0]      wr_addr_q, rd_addr_q;
   logic [CNT_W-1:0] written_q, dropped_q, repeat_q;

   logic [2:0]       sync_q;
   logic             commit_q;

   logic             have_ready;
   idx_t             pick;
   age_t             pick_age;
   logic             found;
   idx_t             free_idx;
   int unsigned      cand;
   logic             rep_inc;
   logic             wr_inc;
   logic [3:0]       drop_inc;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
      logic [CNT_W:0] s;
      logic [CNT_W:0] bz;
      bz      = '0;
      bz[3:0] = b;
      s       = {1'b0, a} + bz;
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   // Commit detect: 2-FF synchroniser plus edge stage, then a registered 1-cycle pulse.
   // Stages reset to 1 so a level still high across reset release never looks like a new edge.
   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         sync_q   <= 3'b111;
         commit_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[1:0], bus.wr_frame_done};
         commit_q <= sync_q[1] & ~sync_q[2];
      end
   end

   // Mode is only allowed to change while nothing is queued, so ordering never mixes.
   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         mode_q <= 1'b0;
      end else if (rc_q == 4'd0) begin
         mode_q <= mode;
      end
   end

   always_comb begin
      st_d     = st_q;
      age_d    = age_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      rep_inc  = 1'b0;
      wr_inc   = 1'b0;
      drop_inc = 4'd0;
      have_ready = 1'b0;
      pick       = '0;
      pick_age   = '0;
      found      = 1'b0;
      free_idx   = '0;
      cand       = 0;
      rc_d       = 4'd0;

      // Reader candidate on the pre-state: newest in LATEST, oldest in QUEUE.
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (st_q[i] == BufReady) begin
            if (!have_ready || (mode_q ? (age_q[i] > pick_age) : (age_q[i] < pick_age))) begin
               have_ready = 1'b1;
               pick       = idx_t'(i);
               pick_age   = age_q[i];
            end
         end
      end

      // Reader step first.
      if (bus.rd_vsync && !freeze) begin
         if (have_ready) begin
            st_d[rd_idx_q] = BufFree;
            st_d[pick]     = BufReading;
            rd_idx_d       = pick;
            valid_d        = 1'b1;
         end else begin
            rep_inc = 1'b1;
         end
      end

      // Writer step on the reader's result.
      if (commit_q) begin
         if (!mode_q) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
               if (st_d[i] == BufReady) begin
                  st_d[i]  = BufFree;
                  drop_inc = drop_inc + 4'd1;
               end
            end
         end
         for (int unsigned off = 1; off < NUM_BUFS; off++) begin
            cand = 32'(wr_idx_q) + off;
            if (cand >= NUM_BUFS) begin
               cand = cand - NUM_BUFS;
            end
            if (!found && st_d[idx_t'(cand)] == BufFree) begin
               found    = 1'b1;
               free_idx = idx_t'(cand);
            end
         end
         if (found) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
               if (st_d[i] == BufReady) begin
                  age_d[i] = age_d[i] + age_t'(1);
               end
            end
            st_d[wr_idx_q]  = BufReady;
            age_d[wr_idx_q] = '0;
            st_d[free_idx]  = BufWriting;
            wr_idx_d        = free_idx;
            wr_inc          = 1'b1;
         end else begin
            // Only reachable in QUEUE: writer keeps its buffer and overwrites it.
            drop_inc = drop_inc + 4'd1;
            ovf_d    = 1'b1;
         end
      end

      for (int i = 0; i < NUM_BUFS; i++) begin
         if (st_d[i] == BufReady) begin
            rc_d = rc_d + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            st_q[i]  <= (i == 0) ? BufWriting :
                        (i == int'(NUM_BUFS) - 1) ? BufReading : BufFree;
            age_q[i] <= '0;
         end
         wr_idx_q  <= '0;
         rd_idx_q  <= idx_t'(NUM_BUFS - 1);
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         rc_q      <= 4'd0;
         wr_addr_q <= BASE_ADDR;
         rd_addr_q <= BASE_ADDR + 32'(NUM_BUFS - 1) * BUF_STRIDE;
         written_q <= '0;
         dropped_q <= '0;
         repeat_q  <= '0;
      end else begin
         st_q      <= st_d;
         age_q     <= age_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         rc_q      <= rc_d;
         wr_addr_q <= BASE_ADDR + 32'(wr_idx_d) * BUF_STRIDE;
         rd_addr_q <= BASE_ADDR + 32'(rd_idx_d) * BUF_STRIDE;
         written_q <= sat_add(written_q, {3'b000, wr_inc});
         dropped_q <= sat_add(dropped_q, drop_inc);
         repeat_q  <= sat_add(repeat_q, {3'b000, rep_inc});
      end
   end

   assign bus.wr_base_addr   = wr_addr_q;
   assign bus.rd_base_addr   = rd_addr_q;
   assign bus.rd_frame_valid = valid_q;
   assign ready_count        = rc_q;
   assign overflow           = ovf_q;
   assign frames_written     = written_q;
   assign frames_dropped     = dropped_q;
   assign frames_repeat      = repeat_q;

endmodule

// File: tb/tb_frame_buf_manager.sv
// Bench for frame_buf_manager: two instances (3 and 5 buffers) driven with the same stimulus and
// compared against a queue-based reference model of buffer ownership.
module tb_frame_buf_manager;

   localparam logic [31:0] BASE   = 32'h0100_0000;
   localparam logic [31:0] STRIDE = 32'h0010_0000;

   logic clk_100Mhz = 1'b0;
   logic rst;
   logic mode, freeze, done, vsync;

   always #5 clk_100Mhz = ~clk_100Mhz;

   frame_buf_manager_if bus3 ();
   frame_buf_manager_if bus5 ();

   assign bus3.wr_frame_done = done;
   assign bus5.wr_frame_done = done;
   assign bus3.rd_vsync      = vsync;
   assign bus5.rd_vsync      = vsync;

   logic [31:0] o_wr [2];
   logic [31:0] o_rd [2];
   logic        o_val[2];
   logic        o_ovf[2];
   logic [3:0]  o_rc [2];
   logic [15:0] o_wn [2];
   logic [15:0] o_dr [2];
   logic [15:0] o_rp [2];

   assign o_wr[0]  = bus3.wr_base_addr;
   assign o_rd[0]  = bus3.rd_base_addr;
   assign o_val[0] = bus3.rd_frame_valid;
   assign o_wr[1]  = bus5.wr_base_addr;
   assign o_rd[1]  = bus5.rd_base_addr;
   assign o_val[1] = bus5.rd_frame_valid;

   frame_buf_manager #(.NUM_BUFS(3)) dut3 (
      .clk_100Mhz     (clk_100Mhz),
      .rst            (rst),
      .bus            (bus3),
      .mode           (mode),
      .freeze         (freeze),
      .ready_count    (o_rc[0]),
      .overflow       (o_ovf[0]),
      .frames_written (o_wn[0]),
      .frames_dropped (o_dr[0]),
      .frames_repeat  (o_rp[0])
   );

   frame_buf_manager #(.NUM_BUFS(5)) dut5 (
      .clk_100Mhz     (clk_100Mhz),
      .rst            (rst),
      .bus            (bus5),
      .mode           (mode),
      .freeze         (freeze),
      .ready_count    (o_rc[1]),
      .overflow       (o_ovf[1]),
      .frames_written (o_wn[1]),
      .frames_dropped (o_dr[1]),
      .frames_repeat  (o_rp[1])
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: READY buffers kept as a list in commit order (oldest first).
   int nb [2] = '{3, 5};
   int m_wr[2], m_rd[2], m_rn[2];
   int m_rq[2][8];
   bit m_valid[2], m_ovf[2];
   int m_written[2], m_dropped[2], m_repeat[2];
   bit m_mode, m_frz;

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_wr[k] = 0;  m_rd[k] = nb[k] - 1;  m_rn[k] = 0;
         m_valid[k] = 0;  m_ovf[k] = 0;
         m_written[k] = 0;  m_dropped[k] = 0;  m_repeat[k] = 0;
      end
   endtask

   function automatic bit m_in_q(input int k, input int b);
      for (int j = 0; j < m_rn[k]; j++) if (m_rq[k][j] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_vsync(input int k);
      if (m_frz) return;
      if (m_rn[k] > 0) begin
         if (m_mode) begin
            m_rd[k] = m_rq[k][0];
            for (int j = 1; j < m_rn[k]; j++) m_rq[k][j-1] = m_rq[k][j];
         end else begin
            m_rd[k] = m_rq[k][m_rn[k]-1];
         end
         m_rn[k]--;
         m_valid[k] = 1'b1;
      end else begin
         m_repeat[k]++;
      end
   endtask

   task automatic m_commit(input int k);
      int f;
      if (!m_mode) begin
         m_dropped[k] += m_rn[k];
         m_rn[k] = 0;
      end
      f = -1;
      for (int off = 1; off < nb[k]; off++) begin
         int c;
         c = (m_wr[k] + off) % nb[k];
         if (f < 0 && c != m_rd[k] && !m_in_q(k, c)) f = c;
      end
      if (f >= 0) begin
         m_rq[k][m_rn[k]] = m_wr[k];
         m_rn[k]++;
         m_wr[k] = f;
         m_written[k]++;
      end else begin
         m_dropped[k]++;
         m_ovf[k] = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         string t;
         t = $sformatf("%s_n%0d", tag, nb[k]);
         chk({t, "_wr_addr"}, o_wr[k], BASE + 32'(m_wr[k]) * STRIDE);
         chk({t, "_rd_addr"}, o_rd[k], BASE + 32'(m_rd[k]) * STRIDE);
         chk({t, "_wr_ne_rd"}, {31'b0, o_wr[k] != o_rd[k]}, 32'd1);
         chk({t, "_valid"}, {31'b0, o_val[k]}, {31'b0, m_valid[k]});
         chk({t, "_ready_cnt"}, {28'b0, o_rc[k]}, 32'(m_rn[k]));
         chk({t, "_overflow"}, {31'b0, o_ovf[k]}, {31'b0, m_ovf[k]});
         chk({t, "_written"}, {16'b0, o_wn[k]}, 32'(m_written[k]));
         chk({t, "_dropped"}, {16'b0, o_dr[k]}, 32'(m_dropped[k]));
         chk({t, "_repeat"}, {16'b0, o_rp[k]}, 32'(m_repeat[k]));
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_100Mhz);
      #1;
   endtask

   // c: commit a frame, v: reader vsync; with both, vsync lands on the commit's update cycle.
   task automatic do_op(input bit c, input bit v);
      if (c) begin
         done = 1'b1;
         step(3);
         vsync = v;
         step(1);
         vsync = 1'b0;
         done  = 1'b0;
      end else begin
         vsync = 1'b1;
         step(1);
         vsync = 1'b0;
      end
      step(4);
      for (int k = 0; k < 2; k++) begin
         if (v) m_vsync(k);
         if (c) m_commit(k);
      end
   endtask

   task automatic set_mode(input bit b);
      mode = b;
      m_mode = b;
      step(2);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      step(2);
      rst = 1'b0;
      step(2);
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; freeze = 1'b0; done = 1'b0; vsync = 1'b0;
      m_mode = 1'b0; m_frz = 1'b0;
      do_reset();
      check_all("reset");
      chk("n5_buf4_addr", o_rd[1], 32'h0140_0000);

      // LATEST: commit then vsync, three times.
      for (int i = 0; i < 3; i++) begin
         do_op(1'b1, 1'b0); check_all("seq_commit");
         do_op(1'b0, 1'b1); check_all("seq_vsync");
      end

      // LATEST: two commits with no vsync, then vsync reads the second frame.
      do_reset();
      do_op(1'b1, 1'b0);
      do_op(1'b1, 1'b0);
      do_op(1'b0, 1'b1);
      check_all("stale");
      chk("stale_dropped_n3", {16'b0, o_dr[0]}, 32'd1);
      chk("stale_rd_addr_n3", o_rd[0], 32'h0110_0000);

      // Same-cycle commit and vsync with one READY frame.
      do_reset();
      do_op(1'b1, 1'b0);
      do_op(1'b1, 1'b1); check_all("same_cycle");
      do_op(1'b0, 1'b1); check_all("same_cycle_next");

      // QUEUE: three commits without vsync, then two vsyncs.
      do_reset();
      set_mode(1'b1);
      for (int i = 0; i < 3; i++) begin
         do_op(1'b1, 1'b0); check_all("queue_commit");
      end
      do_op(1'b0, 1'b1); check_all("queue_rd1");
      do_op(1'b0, 1'b1); check_all("queue_rd2");

      // Freeze over five vsyncs.
      freeze = 1'b1; m_frz = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_op(1'b0, 1'b1); check_all("freeze");
      end
      freeze = 1'b0; m_frz = 1'b0;

      // Reset during an in-flight commit, with wr_frame_done still high at release.
      set_mode(1'b0);
      do_reset();
      do_op(1'b1, 1'b1);
      done = 1'b1;
      step(2);
      rst = 1'b1;
      m_reset();
      #2;
      check_all("rst_async");
      step(2);
      #3 rst = 1'b0;
      step(8);
      check_all("rst_release");
      done = 1'b0;
      step(4);
      check_all("rst_after");

      // Randomised traffic.
      for (int n = 0; n < 200; n++) begin
         int sel;
         if (m_rn[0] == 0 && m_rn[1] == 0 && $urandom_range(0, 3) == 0) set_mode(~m_mode);
         m_frz  = ($urandom_range(0, 4) == 0);
         freeze = m_frz;
         sel = $urandom_range(1, 3);
         do_op(sel[0], sel[1]);
         check_all("rnd");
      end
      freeze = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
